// File: rtl/frame_serializer_pkg.sv
// frame_serializer_pkg: shared state encoding, muxsel source codes and frame sizing.
// Optional parity stage is controlled by the FRAME_SERIALIZER_PARITY_EN macro.
package frame_serializer_pkg;

    // Frame sequencer states; StPar exists only when parity is built in.
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StFlag,
        StHi,
        StLo,
`ifdef FRAME_SERIALIZER_PARITY_EN
        StPar,
`endif
        StStop
    } state_e;

    // Codes reported on muxsel for the source currently driving the line.
    localparam logic [2:0] MuxConst0 = 3'd0;
    localparam logic [2:0] MuxConst1 = 3'd1;
    localparam logic [2:0] MuxThrsh  = 3'd2;
    localparam logic [2:0] MuxRegh   = 3'd3;
    localparam logic [2:0] MuxRegl   = 3'd4;
    localparam logic [2:0] MuxParity = 3'd5;

    // Number of bits in one frame for a given register width.
    function automatic int unsigned frame_bits(input int unsigned width);
`ifdef FRAME_SERIALIZER_PARITY_EN
        return 2 * width + 4;
`else
        return 2 * width + 3;
`endif
    endfunction

endpackage

// File: rtl/frame_serializer_bit_tick.sv
// frame_serializer_bit_tick: bit-period divider. Counts 0..DIV-1 and pulses tick on the
// terminal count; clear holds it at phase 0 so each frame starts aligned.
module frame_serializer_bit_tick #(
    parameter int unsigned DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntTop = CntW'(DIV - 1);

    logic [CntW-1:0] r_cnt;

    assign tick = !clear && (r_cnt == CntTop);

    // Phase counter: wraps on terminal count, held at zero while cleared.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == CntTop) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

endmodule

// File: rtl/frame_serializer.sv
// frame_serializer: sequences start, threshold flag, regh, regl, optional parity and stop
// bits onto one serial line, each bit held DIV clocks. All outputs are registered.
// Parity stage is inserted when FRAME_SERIALIZER_PARITY_EN is defined.
module frame_serializer
    import frame_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIV   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] regh,
    input  logic [WIDTH-1:0] regl,
    input  logic             thrsh,
    output logic             ready,
    output logic             done,
    output logic             selout,
    output logic [2:0]       muxsel
);

    localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IdxW-1:0] IdxTop = IdxW'(WIDTH - 1);

    state_e           r_state;
    state_e           w_state_d;
    logic [IdxW-1:0]  r_bit_idx;
    logic [IdxW-1:0]  w_bit_idx_d;

    logic [WIDTH-1:0] r_regh;
    logic [WIDTH-1:0] r_regl;
    logic             r_thrsh;
    logic             w_load;

    logic             w_tick;
    logic             w_clear;

    logic             r_ready;
    logic             r_done;
    logic             r_selout;
    logic [2:0]       r_muxsel;
    logic             w_ready_d;
    logic             w_done_d;
    logic             w_selout_d;
    logic [2:0]       w_muxsel_d;

    // Divider is held in phase 0 while idle, so the first tick lands DIV cycles into START.
    assign w_clear = (r_state == StIdle);
    assign w_load  = (r_state == StIdle) && start;

    frame_serializer_bit_tick #(
        .DIV (DIV)
    ) u_bit_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_clear),
        .tick  (w_tick)
    );

    // State and bit-index registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_bit_idx <= '0;
        end else begin
            r_state   <= w_state_d;
            r_bit_idx <= w_bit_idx_d;
        end
    end

    // Shadow copies of the frame data, captured only when a frame is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_regh  <= '0;
            r_regl  <= '0;
            r_thrsh <= 1'b0;
        end else if (w_load) begin
            r_regh  <= regh;
            r_regl  <= regl;
            r_thrsh <= thrsh;
        end
    end

    // Next-state and bit-index sequencing; everything after IDLE advances on tick only.
    always_comb begin
        w_state_d   = r_state;
        w_bit_idx_d = r_bit_idx;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_d   = StStart;
                    w_bit_idx_d = '0;
                end
            end
            StStart: begin
                if (w_tick) begin
                    w_state_d = StFlag;
                end
            end
            StFlag: begin
                if (w_tick) begin
                    w_state_d   = StHi;
                    w_bit_idx_d = IdxTop;
                end
            end
            StHi: begin
                if (w_tick) begin
                    if (r_bit_idx == '0) begin
                        w_state_d   = StLo;
                        w_bit_idx_d = IdxTop;
                    end else begin
                        w_bit_idx_d = r_bit_idx - IdxW'(1);
                    end
                end
            end
            StLo: begin
                if (w_tick) begin
                    if (r_bit_idx == '0) begin
`ifdef FRAME_SERIALIZER_PARITY_EN
                        w_state_d = StPar;
`else
                        w_state_d = StStop;
`endif
                    end else begin
                        w_bit_idx_d = r_bit_idx - IdxW'(1);
                    end
                end
            end
`ifdef FRAME_SERIALIZER_PARITY_EN
            StPar: begin
                if (w_tick) begin
                    w_state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (w_tick) begin
                    w_state_d   = StIdle;
                    w_bit_idx_d = '0;
                end
            end
            default: begin
                w_state_d   = StIdle;
                w_bit_idx_d = '0;
            end
        endcase
    end

    // Output decode from the upcoming state, so registered outputs line up with the state.
    always_comb begin
        w_selout_d = 1'b1;
        w_muxsel_d = MuxConst1;
        w_ready_d  = (w_state_d == StIdle);
        w_done_d   = (r_state == StStop) && w_tick;
        case (w_state_d)
            StStart: begin
                w_selout_d = 1'b0;
                w_muxsel_d = MuxConst0;
            end
            StFlag: begin
                w_selout_d = r_thrsh;
                w_muxsel_d = MuxThrsh;
            end
            StHi: begin
                w_selout_d = r_regh[w_bit_idx_d];
                w_muxsel_d = MuxRegh;
            end
            StLo: begin
                w_selout_d = r_regl[w_bit_idx_d];
                w_muxsel_d = MuxRegl;
            end
`ifdef FRAME_SERIALIZER_PARITY_EN
            StPar: begin
                w_selout_d = ^{r_thrsh, r_regh, r_regl};
                w_muxsel_d = MuxParity;
            end
`endif
            default: begin
                w_selout_d = 1'b1;
                w_muxsel_d = MuxConst1;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_selout <= 1'b1;
            r_muxsel <= MuxConst1;
        end else begin
            r_ready  <= w_ready_d;
            r_done   <= w_done_d;
            r_selout <= w_selout_d;
            r_muxsel <= w_muxsel_d;
        end
    end

    assign ready  = r_ready;
    assign done   = r_done;
    assign selout = r_selout;
    assign muxsel = r_muxsel;

endmodule

// File: tb/tb_frame_serializer.sv
// tb_frame_serializer: table vectors, hand-written corner sequences and random frames,
// checked cycle by cycle against a bit-list model of the frame.
module tb_frame_serializer;

    localparam int unsigned W = 4;
    localparam int unsigned D = 4;
`ifdef FRAME_SERIALIZER_PARITY_EN
    localparam int unsigned NB  = 2 * W + 4;
    localparam bit          PAR = 1'b1;
`else
    localparam int unsigned NB  = 2 * W + 3;
    localparam bit          PAR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start, thrsh, ready, done, selout;
    logic [W-1:0] regh, regl;
    logic [2:0]   muxsel;

    logic         f_start, f_thrsh, f_ready, f_done, f_selout;
    logic [W-1:0] f_regh, f_regl;
    logic [2:0]   f_muxsel;

    frame_serializer #(.WIDTH(W), .DIV(D)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .regh(regh), .regl(regl),
        .thrsh(thrsh), .ready(ready), .done(done), .selout(selout), .muxsel(muxsel)
    );

    frame_serializer #(.WIDTH(W), .DIV(1)) u_dut_fast (
        .clk(clk), .rst_n(rst_n), .start(f_start), .regh(f_regh), .regl(f_regl),
        .thrsh(f_thrsh), .ready(f_ready), .done(f_done), .selout(f_selout),
        .muxsel(f_muxsel)
    );

    int checks = 0;
    int errors = 0;

    logic       exp_sel[NB];
    logic [2:0] exp_mux[NB];

    typedef struct {
        logic [W-1:0] h;
        logic [W-1:0] l;
        logic         t;
        logic [10:0]  bits;  // start..stop without parity, first bit in MSB
        logic         par;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Frame as a list of (line value, source code) pairs, one per bit.
    task automatic model_frame(input logic [W-1:0] h, input logic [W-1:0] l, input logic t);
        int k;
        k = 0;
        exp_sel[k] = 1'b0; exp_mux[k] = 3'd0; k++;
        exp_sel[k] = t;    exp_mux[k] = 3'd2; k++;
        for (int i = W - 1; i >= 0; i--) begin
            exp_sel[k] = h[i]; exp_mux[k] = 3'd3; k++;
        end
        for (int i = W - 1; i >= 0; i--) begin
            exp_sel[k] = l[i]; exp_mux[k] = 3'd4; k++;
        end
        if (PAR) begin
            exp_sel[k] = ^{t, h, l}; exp_mux[k] = 3'd5; k++;
        end
        exp_sel[k] = 1'b1; exp_mux[k] = 3'd1;
    endtask

    // Expected frame taken from a hand-written table vector.
    task automatic table_frame(input vec_t v);
        int k;
        k = 0;
        for (int j = 0; j < 2 * W + 2; j++) begin
            exp_sel[k] = v.bits[10-j];
            exp_mux[k] = (j == 0) ? 3'd0 : (j == 1) ? 3'd2 : (j < W + 2) ? 3'd3 : 3'd4;
            k++;
        end
        if (PAR) begin
            exp_sel[k] = v.par; exp_mux[k] = 3'd5; k++;
        end
        exp_sel[k] = v.bits[0]; exp_mux[k] = 3'd1;
    endtask

    // Called one cycle into idle (or in a done cycle); ends sampled in the done cycle.
    task automatic run_frame(input logic [W-1:0] h, input logic [W-1:0] l, input logic t,
                             input string name, input bit disturb);
        regh = h; regl = l; thrsh = t; start = 1'b1;
        step();
        start = 1'b0;
        for (int b = 0; b < int'(NB); b++) begin
            for (int c = 0; c < int'(D); c++) begin
                chk($sformatf("%s.sel[b%0d c%0d]", name, b, c), 32'(selout), 32'(exp_sel[b]));
                chk($sformatf("%s.mux[b%0d c%0d]", name, b, c), 32'(muxsel), 32'(exp_mux[b]));
                chk($sformatf("%s.ready[b%0d c%0d]", name, b, c), 32'(ready), 32'd0);
                chk($sformatf("%s.done[b%0d c%0d]", name, b, c), 32'(done), 32'd0);
                if (disturb && b == 5 && c == 1) begin
                    regh = ~h; regl = ~l; thrsh = ~t; start = 1'b1;
                end
                if (disturb && b == 7 && c == 0) start = 1'b0;
                step();
            end
        end
        chk({name, ".done_pulse"}, 32'(done), 32'd1);
        chk({name, ".done_ready"}, 32'(ready), 32'd1);
        chk({name, ".done_sel"}, 32'(selout), 32'd1);
        chk({name, ".done_mux"}, 32'(muxsel), 32'd1);
    endtask

    task automatic idle_check(input int n, input string name);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            chk($sformatf("%s.ready[%0d]", name, i), 32'(ready), 32'd1);
            chk($sformatf("%s.done[%0d]", name, i), 32'(done), 32'd0);
            chk($sformatf("%s.sel[%0d]", name, i), 32'(selout), 32'd1);
            chk($sformatf("%s.mux[%0d]", name, i), 32'(muxsel), 32'd1);
        end
    endtask

    task automatic run_fast(input logic [W-1:0] h, input logic [W-1:0] l, input logic t,
                            input string name);
        model_frame(h, l, t);
        f_regh = h; f_regl = l; f_thrsh = t; f_start = 1'b1;
        step();
        f_start = 1'b0;
        for (int b = 0; b < int'(NB); b++) begin
            chk($sformatf("%s.sel[%0d]", name, b), 32'(f_selout), 32'(exp_sel[b]));
            chk($sformatf("%s.mux[%0d]", name, b), 32'(f_muxsel), 32'(exp_mux[b]));
            chk($sformatf("%s.ready[%0d]", name, b), 32'(f_ready), 32'd0);
            step();
        end
        chk({name, ".done_pulse"}, 32'(f_done), 32'd1);
        chk({name, ".done_ready"}, 32'(f_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = '{h: 4'b1010, l: 4'b0011, t: 1'b1, bits: 11'b01101000111, par: 1'b1};
        vecs[1] = '{h: 4'b0000, l: 4'b0000, t: 1'b0, bits: 11'b00000000001, par: 1'b0};
        vecs[2] = '{h: 4'b1111, l: 4'b1111, t: 1'b1, bits: 11'b01111111111, par: 1'b1};
        vecs[3] = '{h: 4'b1000, l: 4'b0001, t: 1'b0, bits: 11'b00100000011, par: 1'b0};

        rst_n = 1'b0; start = 1'b0; regh = '0; regl = '0; thrsh = 1'b0;
        f_start = 1'b0; f_regh = '0; f_regl = '0; f_thrsh = 1'b0;

        // Reset held for three cycles, then released.
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst.ready[%0d]", i), 32'(ready), 32'd1);
            chk($sformatf("rst.done[%0d]", i), 32'(done), 32'd0);
            chk($sformatf("rst.sel[%0d]", i), 32'(selout), 32'd1);
            chk($sformatf("rst.mux[%0d]", i), 32'(muxsel), 32'd1);
        end
        rst_n = 1'b1;
        idle_check(2, "post_rst");

        // Table-driven frames, separated by idle cycles.
        for (int v = 0; v < 4; v++) begin
            table_frame(vecs[v]);
            run_frame(vecs[v].h, vecs[v].l, vecs[v].t, $sformatf("vec%0d", v), 1'b0);
            idle_check(2, $sformatf("vec%0d.idle", v));
        end

        // Inputs change and start pulses while busy: frame unaffected, nothing queued.
        model_frame(4'b1010, 4'b0011, 1'b1);
        run_frame(4'b1010, 4'b0011, 1'b1, "disturb", 1'b1);
        idle_check(3 * int'(NB) * int'(D) / 2, "disturb.noqueue");

        // Back-to-back: second start given in the done cycle.
        model_frame(4'b0110, 4'b1001, 1'b0);
        run_frame(4'b0110, 4'b1001, 1'b0, "b2b_a", 1'b0);
        model_frame(4'b1100, 4'b0101, 1'b1);
        run_frame(4'b1100, 4'b0101, 1'b1, "b2b_b", 1'b0);
        idle_check(1, "b2b.idle");

        // Reset asserted during cycle 20 of a frame.
        model_frame(4'b1010, 4'b0011, 1'b1);
        regh = 4'b1010; regl = 4'b0011; thrsh = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 1; cyc < 20; cyc++) begin
            chk($sformatf("midrst.sel[%0d]", cyc), 32'(selout), 32'(exp_sel[(cyc-1)/D]));
            step();
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst.ready", 32'(ready), 32'd1);
        chk("midrst.done", 32'(done), 32'd0);
        chk("midrst.sel", 32'(selout), 32'd1);
        chk("midrst.mux", 32'(muxsel), 32'd1);
        idle_check(int'(NB) * int'(D), "midrst.nodone");
        model_frame(4'b0101, 4'b1110, 1'b0);
        run_frame(4'b0101, 4'b1110, 1'b0, "postrst", 1'b0);
        idle_check(1, "postrst.idle");

        // Minimum divide: one cycle per bit, including a back-to-back frame.
        run_fast(4'hF, 4'h1, 1'b0, "fast");
        step();
        chk("fast.done_clear", 32'(f_done), 32'd0);
        run_fast(4'h3, 4'hC, 1'b1, "fast2");
        run_fast(4'h9, 4'h6, 1'b0, "fast3");
        step();
        chk("fast3.done_clear", 32'(f_done), 32'd0);

        // Random frames on the DIV=4 instance, randomly back-to-back or spaced.
        for (int n = 0; n < 12; n++) begin
            logic [W-1:0] rh, rl;
            logic         rt;
            rh = W'($urandom);
            rl = W'($urandom);
            rt = 1'($urandom_range(0, 1));
            model_frame(rh, rl, rt);
            run_frame(rh, rl, rt, $sformatf("rnd%0d", n), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_check(int'($urandom_range(1, 3)), "rnd.idle");
        end
        idle_check(1, "final.idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
